// File: rtl/nibble_packer.sv
// Packs IN_W-bit nibbles LSB-first into OUT_W-bit words with early flush.
// Optional out_parity port enabled by defining NIBBLE_PACKER_PARITY_EN.
module nibble_packer #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_W-1:0]                   in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    output logic [OUT_W-1:0]                  out_data,
    output logic [$clog2(OUT_W/IN_W):0]       out_count,
    output logic                              out_valid,
    input  logic                              out_ready
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic                              out_parity
`endif
);

    localparam int NUM = OUT_W / IN_W;
    localparam int CW  = $clog2(NUM) + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic             r_valid;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_accept;
    logic             w_last;
    logic             w_close;
    logic [OUT_W-1:0] w_data_nxt;

    always_comb begin
        w_accept   = (r_state == FILL) && in_valid;
        w_last     = (r_count == LAST);
        w_data_nxt = r_data;
        if (w_accept) begin
            w_data_nxt[IN_W*int'(r_count) +: IN_W] = in_data;
        end
        // A flush only closes a word that will hold at least one nibble
        w_close = 1'b0;
        if (r_state == FILL) begin
            w_close = w_accept ? (w_last || flush) : (flush && (r_count != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_data   <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
`ifdef NIBBLE_PACKER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_data   <= w_data_nxt;
                        r_count  <= r_count + CW'(1);
`ifdef NIBBLE_PACKER_PARITY_EN
                        r_parity <= ^w_data_nxt;
`endif
                    end
                    if (w_close) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state  <= FILL;
                        r_data   <= '0;
                        r_count  <= '0;
                        r_valid  <= 1'b0;
`ifdef NIBBLE_PACKER_PARITY_EN
                        r_parity <= 1'b0;
`endif
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready  = (r_state == FILL);
    assign out_data  = r_data;
    assign out_count = r_count;
    assign out_valid = r_valid;
`ifdef NIBBLE_PACKER_PARITY_EN
    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed table, reset sequence
// and randomized traffic against a queue-based word model.
module tb_nibble_packer;

    localparam int IN_W  = 4;
    localparam int OUT_W = 32;
    localparam int NUM   = OUT_W / IN_W;

    logic              clk;
    logic              rst_n;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [OUT_W-1:0]  out_data;
    logic [3:0]        out_count;
    logic              out_valid;
    logic              out_ready;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic              out_parity;
`endif

    int vectors;
    int miscompares;

    nibble_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  d;
        logic        f;
        logic        ordy;
        logic        er;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [3:0] d, input logic f,
                       input logic ordy, input logic er, input logic ev,
                       input logic [31:0] ed, input logic [3:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.ordy = ordy;
        r.er = er; r.ev = ev; r.ed = ed; r.ec = ec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d,
                         input logic f, input logic ordy);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic er, input logic ev,
                           input logic [31:0] ed, input logic [3:0] ec);
        chk({nm, "/in_ready"}, 32'(in_ready), 32'(er));
        chk({nm, "/out_valid"}, 32'(out_valid), 32'(ev));
        if (ev) begin
            chk({nm, "/out_data"}, out_data, ed);
            chk({nm, "/out_count"}, 32'(out_count), 32'(ec));
`ifdef NIBBLE_PACKER_PARITY_EN
            chk({nm, "/out_parity"}, 32'(out_parity), 32'(^ed));
`endif
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: list of accepted nibbles plus a pending-word flag
    bit          m_pend;
    int          m_nibs[$];
    logic [31:0] m_word;
    logic [3:0]  m_cnt;

    task automatic model_edge(input logic v, input logic [3:0] d,
                              input logic f, input logic ordy);
        if (!m_pend) begin
            if (v) m_nibs.push_back(int'(d));
            if (m_nibs.size() == NUM || (f && m_nibs.size() > 0)) begin
                m_word = 0;
                foreach (m_nibs[i]) m_word = m_word + (32'(m_nibs[i]) << (IN_W * i));
                m_cnt  = 4'(m_nibs.size());
                m_pend = 1'b1;
            end
        end else if (ordy) begin
            m_pend = 1'b0;
            m_nibs.delete();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        do_reset();

        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/out_data", out_data, 32'd0);
        chk("reset/out_count", 32'(out_count), 32'd0);

        // Two back-to-back full words: 9 cycles each, valid for one cycle
        for (int w = 0; w < 2; w++) begin
            for (int k = 1; k <= 7; k++) add(1, 4'(k), 0, 1, 1, 0, 0, 0);
            add(1, 4'd8, 0, 1, 0, 1, 32'h87654321, 4'd8);
            add(1, 4'd9, 0, 1, 1, 0, 0, 0);
        end
        // Partial word closed by a lone flush; flush in HOLD ignored
        add(1, 4'hA, 0, 1, 1, 0, 0, 0);
        add(1, 4'hB, 0, 1, 1, 0, 0, 0);
        add(1, 4'hC, 0, 1, 1, 0, 0, 0);
        add(0, 4'h0, 1, 0, 0, 1, 32'h00000CBA, 4'd3);
        add(0, 4'h0, 1, 0, 0, 1, 32'h00000CBA, 4'd3);
        add(0, 4'h0, 0, 1, 1, 0, 0, 0);
        // Flush together with the first nibble; flush on empty ignored
        add(1, 4'h5, 1, 0, 0, 1, 32'h00000005, 4'd1);
        add(0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(0, 4'h0, 1, 1, 1, 0, 0, 0);
        add(0, 4'h0, 1, 1, 1, 0, 0, 0);
        // Flush with the nibble filling the last slot gives a full word
        for (int k = 0; k < 7; k++) add(1, 4'(15 - k), 0, 0, 1, 0, 0, 0);
        add(1, 4'h8, 1, 0, 0, 1, 32'h89ABCDEF, 4'd8);
        add(0, 4'h0, 0, 1, 1, 0, 0, 0);
        // Backpressure: word held 5 cycles, offered nibbles refused
        for (int k = 0; k < 7; k++) add(1, 4'(k), 0, 0, 1, 0, 0, 0);
        add(1, 4'h7, 0, 0, 0, 1, 32'h76543210, 4'd8);
        for (int k = 0; k < 5; k++) add(1, 4'hE, 0, 0, 0, 1, 32'h76543210, 4'd8);
        add(1, 4'hE, 0, 1, 1, 0, 0, 0);
        add(1, 4'h3, 1, 0, 0, 1, 32'h00000003, 4'd1);
        add(0, 4'h0, 0, 1, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].ordy);
            chk_out($sformatf("row%0d", i), tbl[i].er, tbl[i].ev,
                    tbl[i].ed, tbl[i].ec);
        end

        // Asynchronous reset in the middle of a word
        for (int k = 0; k < 5; k++) drive(1, 4'(k + 1), 0, 1);
        rst_n = 1'b0;
        #2;
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/out_data", out_data, 32'd0);
        chk("midrst/out_count", 32'(out_count), 32'd0);
`ifdef NIBBLE_PACKER_PARITY_EN
        chk("midrst/out_parity", 32'(out_parity), 32'd0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst/in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 7; k++) begin
            drive(1, 4'hF, 0, 1);
            chk_out("allF/fill", 1, 0, 0, 0);
        end
        drive(1, 4'hF, 0, 1);
        chk_out("allF/word", 0, 1, 32'hFFFFFFFF, 4'd8);
        drive(0, 4'h0, 0, 1);
        chk_out("allF/done", 1, 0, 0, 0);

        // Randomized traffic against the model
        do_reset();
        m_pend = 1'b0;
        m_nibs.delete();
        for (int c = 0; c < 3000; c++) begin
            logic v, f, o;
            logic [3:0] d;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 7) == 0);
            o = ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            drive(v, d, f, o);
            model_edge(v, d, f, o);
            chk_out($sformatf("rand%0d", c), !m_pend, m_pend, m_word, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter IN_W, default 4, width of one input nibble in bits.
REQ-002 SHALL have parameter OUT_W, default 32, width of the packed output word; SHALL be a positive multiple of IN_W; NUM = OUT_W/IN_W slots.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  IN_W  nibble from the upstream cast stage.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port flush  input  1  close the partial word early, zero-padded.
REQ-009 SHALL have port out_data  output  OUT_W  packed word.
REQ-010 SHALL have port out_count  output  $clog2(NUM)+1  number of valid nibbles in out_data (1..NUM).
REQ-011 SHALL have port out_valid  output  1  out_data/out_count are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word.

Function
REQ-013 SHALL implement two states: FILL (collecting) and HOLD (word presented).
REQ-014 In FILL, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-015 A nibble SHALL be accepted only when in_valid and in_ready are both 1 on a clock edge.
REQ-016 The k-th accepted nibble of a word (k from 0) SHALL be stored at out_data bits [IN_W*k +: IN_W]; first nibble in the LSBs.
REQ-017 Slot counter SHALL increment by 1 per accepted nibble and SHALL reset to 0 on entering FILL.
REQ-018 Acceptance of slot NUM-1 SHALL move FILL->HOLD; out_valid SHALL be 1 on the following cycle (latency 1), out_count = NUM.
REQ-019 flush=1 in FILL with count>0 SHALL move to HOLD; unfilled slots SHALL read 0; out_count = slots filled.
REQ-020 flush and an accepted nibble in the same cycle SHALL include that nibble in the flushed word; if that nibble fills slot NUM-1, result equals a normal full word.
REQ-021 flush in FILL with count=0 and no accepted nibble SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-022 In HOLD, out_data, out_count, out_valid SHALL remain stable until out_valid and out_ready are both 1.
REQ-023 Handshake out_valid&&out_ready SHALL move HOLD->FILL, clear the data register to 0 and set count=0; in_ready rises the next cycle.
REQ-024 out_valid SHALL be 0 in FILL; out_valid SHALL NOT depend combinationally on out_ready.
REQ-025 Sustained throughput SHALL be one word per NUM+1 cycles with out_ready held 1.

Reset
REQ-026 On rst_n=0, asynchronously: state=FILL, count=0, out_data=0, out_count=0, out_valid=0; in_ready SHALL read 1 after release.
REQ-027 Reset mid-word or in HOLD SHALL discard the partial/held word; no output handshake for it.

Configuration
REQ-028 Macro NIBBLE_PACKER_PARITY_EN SHALL, when defined, add port out_parity  output  1  XOR-reduction of out_data, registered with out_data, 0 at reset.
REQ-029 Without NIBBLE_PACKER_PARITY_EN, out_parity SHALL NOT exist; all other behaviour identical.

Verification
REQ-030 Feed nibbles 1,2,...,8 back-to-back, out_ready=1 -> one word 32'h87654321, out_count=8, out_valid exactly 1 cycle, 9 cycles per word.
REQ-031 Feed 4'hA,4'hB,4'hC then flush alone -> out_data=32'h00000CBA, out_count=3.
REQ-032 Feed 4'h5 with flush in same cycle at count=0 -> out_data=32'h00000005, out_count=1; flush at count=0 with in_valid=0 -> no output.
REQ-033 Full word, out_ready=0 for 5 cycles -> out_data stable, in_ready=0, in_valid nibbles not accepted; release -> handshake, FILL next cycle.
REQ-034 rst_n low after 5 nibbles -> outputs 0; next 8 nibbles 4'hF -> 32'hFFFFFFFF, out_count=8 (parity build: out_parity=0).
